serial_tx_fifo: RTL and testbench
=================================

Name: serial_tx_fifo

Overview:
Byte buffer and issue controller that sits directly upstream of the UART transmitter, serial_tx. Producers such as command handlers and status reporters push bytes at clock rate. The block holds them in a FIFO and presents them one at a time on the transmitter's data/new_data inputs. It paces issue on the transmitter's registered busy output, including the one-cycle lag before busy rises after new_data.

Parameters:
DEPTH, 16, FIFO capacity in bytes; must be a power of 2 and at least 2.
ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  synchronous reset, active-high.
wr_data  in  8  byte to enqueue.
wr_en  in  1  enqueue strobe; sampled every clk.
full  out  1  FIFO holds DEPTH bytes.
empty  out  1  FIFO holds 0 bytes.
level  out  ADDR_W+1  current byte count, 0..DEPTH.
overflow  out  1  sticky; set when a write is dropped.
tx_data  out  8  byte to the transmitter's data input.
tx_new_data  out  1  single-cycle issue strobe to the transmitter's new_data input.
tx_busy  in  1  transmitter's busy output.

Behaviour:
- Reset (rst=1 at an edge):
  - rd_ptr, wr_ptr and level go to 0; empty=1, full=0, overflow=0.
  - tx_data=8'h00, tx_new_data=0, FSM goes to IDLE.
  - Memory contents are not cleared.
  - Reset mid-transfer discards all queued bytes. The byte already handed to the transmitter is the transmitter's responsibility.
- Write:
  - Accepted at an edge iff wr_en=1 and full=0 before that edge: mem[wr_ptr]<=wr_data, wr_ptr+1 (wraps mod DEPTH).
  - wr_en=1 with full=1: byte dropped, overflow<=1, held until reset.
  - A same-cycle pop does not free space for the write.
- Pointers: ADDR_W bits, natural wrap. full/empty/level are registered and derived from a registered count, which is updated as +1 on write only, -1 on pop only, and unchanged on both or neither.
- FSM (registered, 4 states):
  - IDLE: if empty=0 and tx_busy=0 → pop (tx_data<=mem[rd_ptr], rd_ptr+1), go to SEND. Otherwise stay.
  - SEND: tx_new_data=1 for exactly this cycle, tx_data stable; go to HOLD unconditionally.
  - HOLD: 1 cycle, tx_new_data=0, tx_busy ignored because the transmitter's busy is not yet visible; go to WAIT.
  - WAIT: stay while tx_busy=1; on tx_busy=0 go to IDLE.
- tx_new_data is a decoded registered state (state==SEND), glitch-free, never high two consecutive cycles.
- tx_data changes only on pop and is held through SEND/HOLD/WAIT.
- Latency:
  - Write sampled at edge k into an empty FIFO with the transmitter idle: empty falls after k, pop at k+1, tx_new_data high between k+1 and k+2.
  - Back-to-back bytes: the next pop occurs on the edge after the edge at which IDLE is re-entered, i.e. 2 clocks after busy falls.
- tx_busy held high (transmitter blocked): the FSM waits indefinitely in IDLE/WAIT. No timeout, no byte loss.
- Simultaneous write and pop at level=DEPTH: the write is dropped (full rule) and the pop proceeds; level becomes DEPTH-1, overflow=1.
- Simultaneous write and pop at level=1: level stays 1 and empty stays 0.

Test Plan:
- Reset then idle, tx_busy=0 → full=0, empty=1, level=0, overflow=0, tx_new_data never asserts over 50 cycles.
- Write 8'hA5 at edge 10 with tx_busy=0 → tx_new_data high only in cycle 11–12 with tx_data=8'hA5; level returns to 0.
- Write 3 bytes 8'h01/02/03 back-to-back; a transmitter model raises busy 1 cycle after new_data and holds it 20 cycles → three strobes in order 01, 02, 03, each ≥22 cycles apart, never overlapping busy.
- Hold tx_busy=1, write DEPTH+2 bytes (16+2) → full=1 after 16 writes, level=16, overflow=1, last 2 bytes absent; release busy → exactly 16 bytes emerge in write order, pointer wrap verified.
- At level=1, write and pop in the same cycle → level stays 1, empty=0; at level=16, write+pop → level=15, overflow=1.
- Assert rst while in WAIT with 5 bytes queued → next cycle level=0, empty=1, tx_new_data=0, tx_data=8'h00; a subsequent single write issues normally.

Source files
------------

// File: rtl/serial_tx_fifo.sv
// Byte FIFO feeding the serial_tx UART transmitter; issues one byte at a time
// and paces on the transmitter's registered busy flag.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | waiting for a queued byte and an idle transmitter
// ST_SEND | byte popped, tx_new_data strobe high for this cycle
// ST_HOLD | one-cycle gap while the transmitter's busy becomes visible
// ST_WAIT | waiting for the transmitter to drop busy
module serial_tx_fifo #(
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        wr_data,
  input  logic              wr_en,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic [7:0]        tx_data,
  output logic              tx_new_data,
  input  logic              tx_busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_HOLD = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  state_t            state, state_nxt;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count, count_nxt;
  logic              wr_ok, pop;

  // full/empty come from registered flags, so a pop in the same cycle never frees space for a write
  assign wr_ok       = wr_en & ~full;
  assign pop         = (state == ST_IDLE) & ~empty & ~tx_busy;
  assign level       = count;
  assign tx_new_data = (state == ST_SEND);

  always_comb begin
    count_nxt = count;
    case ({wr_ok, pop})
      2'b10:   count_nxt = count + (ADDR_W+1)'(1);
      2'b01:   count_nxt = count - (ADDR_W+1)'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      if (pop) begin
        tx_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + ADDR_W'(1);
      end
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_CNT);
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (pop) state_nxt = ST_SEND;
      ST_SEND: state_nxt = ST_HOLD;
      ST_HOLD: state_nxt = ST_WAIT;
      ST_WAIT: if (!tx_busy) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_tx_fifo.sv
// Self-checking bench for serial_tx_fifo: scoreboard of accepted bytes checked
// against every tx_new_data strobe, plus a simple busy model of serial_tx.
module tb_serial_tx_fifo;

  localparam int DEPTH    = 16;
  localparam int BUSY_LEN = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] wr_data = 8'h00;
  logic       wr_en = 1'b0;
  logic       full, empty, overflow, tx_new_data, tx_busy;
  logic [4:0] level;
  logic [7:0] tx_data;

  logic       block = 1'b0;
  int         busy_cnt = 0;

  logic [7:0] q[$];
  int         n_chk = 0;
  int         n_pass = 0;
  int         n_acc = 0;
  int         n_strobes = 0;
  int         strobe_base = 0;
  int         cyc = 0;
  int         last_strobe = -1;
  logic       prev_nd = 1'b0;

  serial_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .full       (full),
    .empty      (empty),
    .level      (level),
    .overflow   (overflow),
    .tx_data    (tx_data),
    .tx_new_data(tx_new_data),
    .tx_busy    (tx_busy)
  );

  always #5 clk = ~clk;

  // transmitter: busy rises the cycle after new_data and stays up BUSY_LEN cycles
  assign tx_busy = block | (busy_cnt != 0);
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_new_data) busy_cnt <= BUSY_LEN;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (tx_new_data) begin
      n_strobes++;
      check("strobe_repeat", 32'(prev_nd), 32'd0);
      check("strobe_busy", 32'(tx_busy), 32'd0);
      if (last_strobe >= 0) check("strobe_gap", 32'((cyc - last_strobe) >= BUSY_LEN + 2), 32'd1);
      last_strobe = cyc;
      check("sb_nonempty", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) check("tx_data", 32'(tx_data), 32'(q.pop_front()));
    end
    prev_nd = tx_new_data;
  end

  // called at a negedge; returns at the following negedge
  task automatic push(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    @(posedge clk);
    if (n_acc - (n_strobes - strobe_base) < DEPTH) begin
      q.push_back(b);
      n_acc++;
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    int quiet = 0;
    while (quiet < 4 && n < 3000) begin
      @(negedge clk);
      n++;
      if (q.size() == 0 && !tx_busy && empty && !tx_new_data) quiet++;
      else quiet = 0;
    end
    check({tag, "_timeout"}, 32'(n < 3000), 32'd1);
  endtask

  initial begin
    int s0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("rst_full", 32'(full), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_level", 32'(level), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    s0 = n_strobes;
    repeat (50) @(negedge clk);
    check("idle_no_strobe", 32'(n_strobes - s0), 32'd0);

    // single byte latency
    push(8'hA5);
    check("a5_empty_k", 32'(empty), 32'd0);
    check("a5_level_k", 32'(level), 32'd1);
    check("a5_nd_k", 32'(tx_new_data), 32'd0);
    @(negedge clk);
    check("a5_nd_k1", 32'(tx_new_data), 32'd1);
    check("a5_data_k1", 32'(tx_data), 32'hA5);
    check("a5_level_k1", 32'(level), 32'd0);
    check("a5_empty_k1", 32'(empty), 32'd1);
    @(negedge clk);
    check("a5_nd_k2", 32'(tx_new_data), 32'd0);
    check("a5_hold_data", 32'(tx_data), 32'hA5);
    drain("a5");

    // three bytes back-to-back; second write coincides with the first pop at level 1
    s0 = n_strobes;
    push(8'h01);
    push(8'h02);
    check("l1_level", 32'(level), 32'd1);
    check("l1_empty", 32'(empty), 32'd0);
    check("l1_nd", 32'(tx_new_data), 32'd1);
    push(8'h03);
    check("three_level", 32'(level), 32'd2);
    drain("three");
    check("three_count", 32'(n_strobes - s0), 32'd3);

    // blocked transmitter: fill past DEPTH
    block = 1'b1;
    for (int i = 0; i < DEPTH; i++) push(8'h40 + 8'(i));
    check("fill_full", 32'(full), 32'd1);
    check("fill_level", 32'(level), 32'd16);
    check("fill_ovf_clear", 32'(overflow), 32'd0);
    push(8'hE1);
    push(8'hE2);
    check("ovf_full", 32'(full), 32'd1);
    check("ovf_level", 32'(level), 32'd16);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_sb_size", 32'(q.size()), 32'd16);
    // release busy while writing again at level 16: write dropped, pop proceeds
    s0 = n_strobes;
    block = 1'b0;
    push(8'hEE);
    check("l16_level", 32'(level), 32'd15);
    check("l16_full", 32'(full), 32'd0);
    check("l16_ovf", 32'(overflow), 32'd1);
    check("l16_nd", 32'(tx_new_data), 32'd1);
    drain("wrap");
    check("wrap_count", 32'(n_strobes - s0), 32'd16);

    // reset while waiting on the transmitter with 5 bytes queued
    for (int i = 0; i < 6; i++) push(8'h10 + 8'(i));
    repeat (4) @(negedge clk);
    check("pre_rst_level", 32'(level), 32'd5);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    n_acc = 0;
    strobe_base = n_strobes;
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_nd", 32'(tx_new_data), 32'd0);
    check("mid_rst_data", 32'(tx_data), 32'h00);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    s0 = n_strobes;
    push(8'h5A);
    drain("post_rst");
    check("post_rst_count", 32'(n_strobes - s0), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
